mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, number of requesting channels; channel 0 has the lowest index.
REQ-002 SHALL have parameter MAX_BYTES, default 4, the largest access size; legal values are 1, 2 and 4.
REQ-003 SHALL have parameter IO_REGION, default 2'b11; an address whose bits [17:16] equal this value is an IO address.
REQ-004 Ports: clk_in in 1, the single clock; rst_n_in in 1, reset, synchronous and active-low.
REQ-005 Ports: rdy_in in 1, global enable; all state freezes while it is low.
REQ-006 Ports: flush_in in 1, speculative flush.
REQ-007 Ports: ch_valid in NUM_CH, request valid per channel.
REQ-008 Ports: ch_wr in NUM_CH, 1 = write.
REQ-009 Ports: ch_len in 3*NUM_CH; bits [1:0] encode size (00 = 1 byte, 01 = 2 bytes, 10 = 4 bytes); bit [2] selects signed load.
REQ-010 Ports: ch_addr in 32*NUM_CH, byte address.
REQ-011 Ports: ch_wdata in 32*NUM_CH, write data.
REQ-012 Ports: ch_done out NUM_CH, one-cycle completion pulse.
REQ-013 Ports: rdata out 32, load result for the channel that completes.
REQ-014 Ports: mem_din in 8, RAM read byte.
REQ-015 Ports: mem_dout out 8, RAM write byte.
REQ-016 Ports: mem_a out 32, RAM address; only bits [17:0] are meaningful.
REQ-017 Ports: mem_wr out 1, 1 = write.
REQ-018 Ports: io_buffer_full in 1, the IO sink cannot accept a write.

Function
REQ-019 SHALL implement a 4-state FSM: IDLE, XFER, LAST, DONE.
REQ-020 In IDLE with at least one ch_valid set, SHALL grant one channel round-robin, starting the search at the channel after the last granted one, and latch its wr, len, addr and wdata (the accept edge T).
REQ-021 SHALL NOT grant an IO write while io_buffer_full is high; that channel is skipped for the cycle and the other channels remain eligible.
REQ-022 Access of n bytes: SHALL drive byte k (k = 0..n-1) in cycle T+1+k, with mem_a = addr+k, mem_wr = wr, and mem_dout = wdata[8k+7:8k].
REQ-023 RAM read data SHALL be taken from mem_din one cycle after its address; byte k is captured at the end of cycle T+2+k.
REQ-024 XFER SHALL cover cycles T+1..T+n; a read then enters LAST for 1 cycle to capture the final byte, while a write goes directly to DONE.
REQ-025 In DONE, ch_done[granted] SHALL be high for exactly 1 cycle and rdata SHALL be valid in that same cycle; the FSM then returns to IDLE.
REQ-026 Read latency SHALL be n+2 cycles from the accept edge to the done cycle; write latency SHALL be n+1 cycles.
REQ-027 Outside XFER, mem_wr SHALL be 0 and mem_dout SHALL be 0; mem_a SHALL hold its last value, except after an IO access, when it SHALL be forced to 0 to avoid repeated IO reads.
REQ-028 rdata extension, unsigned: 1 byte = {24'b0, b0}; 2 bytes = {16'b0, b1, b0}.
REQ-029 rdata extension, signed: 1 byte replicates b0[7]; 2 bytes replicate b1[7].
REQ-030 A 4-byte read SHALL return {b3, b2, b1, b0} for both signed and unsigned.
REQ-031 rdata SHALL be 0 for a write and for any illegal len; a len larger than MAX_BYTES, or ch_len[1:0] = 11, SHALL be treated as 1 byte.
REQ-032 flush_in during a read SHALL abort it at the next edge: return to IDLE, no ch_done pulse, mem_wr = 0.
REQ-033 flush_in during a write SHALL NOT abort it; the write SHALL complete all bytes and pulse ch_done.
REQ-034 flush_in in IDLE SHALL suppress any grant in that cycle.
REQ-035 A requester SHALL hold ch_valid and its payload stable until its ch_done pulse; a payload change is undefined.
REQ-036 A new grant SHALL be possible in the cycle after DONE, giving back-to-back transfers with one idle cycle between them.
REQ-037 Address arithmetic addr+k SHALL wrap modulo 2^32.
REQ-038 With rdy_in low, no output, register or FSM state SHALL change.

Reset
REQ-039 While rst_n_in is sampled low: FSM = IDLE, round-robin pointer = NUM_CH-1 (so channel 0 wins first), ch_done = 0, rdata = 0, mem_a = 0, mem_dout = 0, mem_wr = 0.
REQ-040 Reset asserted mid-transfer SHALL abandon the transfer at that edge regardless of rdy_in, with no ch_done pulse.

Structure
REQ-041 A shared package SHALL hold the FSM state enum, the len encodings (LEN_B, LEN_H, LEN_W, LEN_SIGNED) and the IO_REGION default.
REQ-042 Round-robin selection SHALL be a sub-module rr_arbiter (NUM_CH request/mask in, one-hot grant out, purely combinational); the pointer register SHALL stay in mem_arbiter.

Verification
REQ-043 Ch0 signed byte read at 0x100 with mem holding 0x80: mem_a = 0x100 at T+1, ch_done[0] at T+3, rdata = 0xFFFFFF80.
REQ-044 Ch1 word write 0xDEADBEEF at 0x200: mem_dout = EF, BE, AD, DE on mem_a = 0x200..0x203 with mem_wr = 1, then ch_done[1] at T+5.
REQ-045 Both channels valid continuously: grants alternate 0, 1, 0, 1, with one idle cycle between transfers.
REQ-046 flush_in at T+2 of a word read: no ch_done, FSM in IDLE at T+3; flush_in at T+2 of a word write: all 4 bytes written and ch_done at T+5.
REQ-047 IO write to 0x30000 with io_buffer_full = 1 for 3 cycles, ch0 read also pending: ch0 is served first; the IO write is granted only after full drops; afterwards mem_a = 0.
REQ-048 rdy_in held low for 2 cycles mid half-word read, and rst_n_in pulsed low mid-transfer: the transfer stretches by exactly 2 cycles; the reset returns to IDLE with all outputs 0.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared types, len encodings and load extension for mem_arbiter
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_LAST = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [1:0] LEN_B         = 2'b00;
  localparam logic [1:0] LEN_H         = 2'b01;
  localparam logic [1:0] LEN_W         = 2'b10;
  localparam logic [2:0] LEN_SIGNED    = 3'b100;
  localparam logic [1:0] IO_REGION_DEF = 2'b11;

  function automatic logic [31:0] extend_load(input logic [31:0] b, input logic [1:0] size,
                                              input logic sgn);
    case (size)
      LEN_B:   extend_load = {{24{sgn & b[7]}}, b[7:0]};
      LEN_H:   extend_load = {{16{sgn & b[15]}}, b[15:0]};
      default: extend_load = b;
    endcase
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_arbiter.sv
// rtl/mem_arbiter_rr_arbiter.sv - combinational round-robin pick: lowest masked request,
// falling back to the lowest unmasked request when the mask window is empty
module rr_arbiter #(
  parameter int NUM_CH = 2
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [NUM_CH-1:0] mask,
  output logic [NUM_CH-1:0] gnt
);

  logic [NUM_CH-1:0] masked;
  logic              use_masked;

  always_comb begin
    masked     = req & mask;
    use_masked = |masked;
    gnt        = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (use_masked ? masked[i] : req[i]) begin
        gnt    = '0;
        gnt[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - multi-channel byte-serial RAM/IO arbiter with round-robin grant,
// sign extension, speculative read flush and global freeze
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int         NUM_CH    = 2,
  parameter int         MAX_BYTES = 4,
  parameter logic [1:0] IO_REGION = IO_REGION_DEF
) (
  input  logic                   clk_in,
  input  logic                   rst_n_in,
  input  logic                   rdy_in,
  input  logic                   flush_in,
  input  logic [NUM_CH-1:0]      ch_valid,
  input  logic [NUM_CH-1:0]      ch_wr,
  input  logic [3*NUM_CH-1:0]    ch_len,
  input  logic [32*NUM_CH-1:0]   ch_addr,
  input  logic [32*NUM_CH-1:0]   ch_wdata,
  output logic [NUM_CH-1:0]      ch_done,
  output logic [31:0]            rdata,
  input  logic [7:0]             mem_din,
  output logic [7:0]             mem_dout,
  output logic [31:0]            mem_a,
  output logic                   mem_wr,
  input  logic                   io_buffer_full
);

  localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  state_t            state;
  logic [IW-1:0]     ptr;
  logic [NUM_CH-1:0] gnt_q;
  logic              wr_q;
  logic              sgn_q;
  logic              legal_q;
  logic              io_q;
  logic [1:0]        size_q;
  logic [1:0]        last_q;
  logic [1:0]        cnt;
  logic [31:0]       addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rbuf;

  logic [NUM_CH-1:0] elig;
  logic [NUM_CH-1:0] mask;
  logic [NUM_CH-1:0] gnt;
  logic              sel_wr;
  logic [2:0]        sel_len;
  logic [31:0]       sel_addr;
  logic [31:0]       sel_wdata;
  logic [IW-1:0]     sel_idx;
  logic [2:0]        sel_bytes;
  logic              sel_legal;
  logic [1:0]        sel_last;
  logic [1:0]        nxt;
  logic [1:0]        prv;
  logic [31:0]       fin_buf;

  // IO writes are hidden from the arbiter while the sink is full
  always_comb begin
    elig = '0;
    mask = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      elig[i] = ch_valid[i] &
                ~(ch_wr[i] & (ch_addr[32*i+16 +: 2] == IO_REGION) & io_buffer_full);
      mask[i] = (i > int'(ptr));
    end
  end

  rr_arbiter #(.NUM_CH(NUM_CH)) u_rr (
    .req  (elig),
    .mask (mask),
    .gnt  (gnt)
  );

  always_comb begin
    sel_wr    = 1'b0;
    sel_len   = '0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_idx   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (gnt[i]) begin
        sel_wr    = ch_wr[i];
        sel_len   = ch_len[3*i +: 3];
        sel_addr  = ch_addr[32*i +: 32];
        sel_wdata = ch_wdata[32*i +: 32];
        sel_idx   = IW'(i);
      end
    end
    case (sel_len[1:0])
      LEN_B:   sel_bytes = 3'd1;
      LEN_H:   sel_bytes = 3'd2;
      LEN_W:   sel_bytes = 3'd4;
      default: sel_bytes = 3'd0;
    endcase
    sel_legal = (sel_bytes != 3'd0) && (int'(sel_bytes) <= MAX_BYTES);
    sel_last  = sel_legal ? 2'(sel_bytes - 3'd1) : 2'd0;
  end

  // the final read byte arrives in LAST and is merged before extension
  always_comb begin
    nxt     = cnt + 2'd1;
    prv     = cnt - 2'd1;
    fin_buf = rbuf;
    fin_buf[{last_q, 3'b000} +: 8] = mem_din;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state   <= ST_IDLE;
      ptr     <= IW'(NUM_CH - 1);
      gnt_q   <= '0;
      wr_q    <= 1'b0;
      sgn_q   <= 1'b0;
      legal_q <= 1'b0;
      io_q    <= 1'b0;
      size_q  <= '0;
      last_q  <= '0;
      cnt     <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rbuf    <= '0;
      ch_done <= '0;
      rdata   <= '0;
      mem_a   <= '0;
      mem_dout <= '0;
      mem_wr  <= 1'b0;
    end else if (rdy_in) begin
      ch_done <= '0;
      case (state)
        ST_IDLE: begin
          if (!flush_in && (|gnt)) begin
            state    <= ST_XFER;
            ptr      <= sel_idx;
            gnt_q    <= gnt;
            wr_q     <= sel_wr;
            sgn_q    <= |(sel_len & LEN_SIGNED);
            legal_q  <= sel_legal;
            io_q     <= (sel_addr[17:16] == IO_REGION);
            size_q   <= sel_len[1:0];
            last_q   <= sel_last;
            cnt      <= '0;
            addr_q   <= sel_addr;
            wdata_q  <= sel_wdata;
            rbuf     <= '0;
            mem_a    <= sel_addr;
            mem_wr   <= sel_wr;
            mem_dout <= sel_wdata[7:0];
          end
        end
        ST_XFER: begin
          if (flush_in && !wr_q) begin
            state    <= ST_IDLE;
            mem_wr   <= 1'b0;
            mem_dout <= '0;
            if (io_q) mem_a <= '0;
          end else begin
            if (cnt != 2'd0) rbuf[{prv, 3'b000} +: 8] <= mem_din;
            if (cnt == last_q) begin
              state    <= wr_q ? ST_DONE : ST_LAST;
              mem_wr   <= 1'b0;
              mem_dout <= '0;
              if (io_q) mem_a <= '0;
              if (wr_q) begin
                ch_done <= gnt_q;
                rdata   <= '0;
              end
            end else begin
              cnt      <= nxt;
              mem_a    <= addr_q + {30'd0, nxt};
              mem_dout <= wdata_q[{nxt, 3'b000} +: 8];
            end
          end
        end
        ST_LAST: begin
          if (flush_in) begin
            state <= ST_IDLE;
          end else begin
            state   <= ST_DONE;
            ch_done <= gnt_q;
            rdata   <= legal_q ? extend_load(fin_buf, size_q, sgn_q) : 32'd0;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic        rdy_in;
  logic        flush_in;
  logic [1:0]  ch_valid;
  logic [1:0]  ch_wr;
  logic [5:0]  ch_len;
  logic [63:0] ch_addr;
  logic [63:0] ch_wdata;
  logic [1:0]  ch_done;
  logic [31:0] rdata;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;

  logic        pl_we;
  logic [9:0]  pl_a;
  logic [7:0]  pl_d;
  logic [7:0]  ram [0:1023];
  logic [7:0]  exp_b [4];
  logic [1:0]  exp_done;

  int n_tests = 0;
  int n_fail  = 0;

  mem_arbiter #(.NUM_CH(2), .MAX_BYTES(4), .IO_REGION(2'b11)) dut (
    .clk_in         (clk_in),
    .rst_n_in       (rst_n_in),
    .rdy_in         (rdy_in),
    .flush_in       (flush_in),
    .ch_valid       (ch_valid),
    .ch_wr          (ch_wr),
    .ch_len         (ch_len),
    .ch_addr        (ch_addr),
    .ch_wdata       (ch_wdata),
    .ch_done        (ch_done),
    .rdata          (rdata),
    .mem_din        (mem_din),
    .mem_dout       (mem_dout),
    .mem_a          (mem_a),
    .mem_wr         (mem_wr),
    .io_buffer_full (io_buffer_full)
  );

  always #5 clk_in = ~clk_in;

  // synchronous RAM, frozen together with the arbiter when rdy_in is low
  always @(posedge clk_in) begin
    if (pl_we) ram[pl_a] <= pl_d;
    else if (rdy_in) begin
      if (mem_wr) ram[mem_a[9:0]] <= mem_dout;
      mem_din <= ram[mem_a[9:0]];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic pre(input logic [9:0] a, input logic [7:0] d);
    pl_a = a; pl_d = d; pl_we = 1'b1;
    cyc(1);
    pl_we = 1'b0;
  endtask

  task automatic set_ch(input int c, input logic v, input logic w, input logic [2:0] len,
                        input logic [31:0] a, input logic [31:0] d);
    ch_valid[c] = v;
    ch_wr[c] = w;
    ch_len[3*c +: 3] = len;
    ch_addr[32*c +: 32] = a;
    ch_wdata[32*c +: 32] = d;
  endtask

  initial begin
    rst_n_in = 1'b0; rdy_in = 1'b1; flush_in = 1'b0; io_buffer_full = 1'b0;
    ch_valid = '0; ch_wr = '0; ch_len = '0; ch_addr = '0; ch_wdata = '0;
    pl_we = 1'b0; pl_a = '0; pl_d = '0;
    cyc(2);
    chk("rst_state", 32'(dut.state), 32'(ST_IDLE));
    chk("rst_done", 32'(ch_done), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_mem_a", mem_a, 32'd0);
    chk("rst_dout", 32'(mem_dout), 32'd0);
    chk("rst_wr", 32'(mem_wr), 32'd0);
    pre(10'h100, 8'h80);
    pre(10'h110, 8'h34);
    pre(10'h111, 8'h92);
    rst_n_in = 1'b1;
    cyc(1);

    // ch0 signed byte read
    set_ch(0, 1'b1, 1'b0, 3'b100, 32'h100, 32'h0);
    cyc(1);
    chk("sb_mem_a_t1", mem_a, 32'h100);
    chk("sb_wr_t1", 32'(mem_wr), 32'd0);
    cyc(1);
    chk("sb_done_t2", 32'(ch_done), 32'd0);
    cyc(1);
    chk("sb_done_t3", 32'(ch_done), 32'b01);
    chk("sb_rdata", rdata, 32'hFFFFFF80);
    set_ch(0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    cyc(1);
    chk("sb_done_clear", 32'(ch_done), 32'd0);

    // ch1 word write
    exp_b[0] = 8'hEF; exp_b[1] = 8'hBE; exp_b[2] = 8'hAD; exp_b[3] = 8'hDE;
    set_ch(1, 1'b1, 1'b1, 3'b010, 32'h200, 32'hDEADBEEF);
    for (int k = 0; k < 4; k++) begin
      cyc(1);
      chk("ww_mem_a", mem_a, 32'h200 + 32'(k));
      chk("ww_dout", 32'(mem_dout), 32'(exp_b[k]));
      chk("ww_wr", 32'(mem_wr), 32'd1);
    end
    cyc(1);
    chk("ww_done_t5", 32'(ch_done), 32'b10);
    chk("ww_rdata", rdata, 32'd0);
    chk("ww_wr_after", 32'(mem_wr), 32'd0);
    chk("ww_dout_after", 32'(mem_dout), 32'd0);
    chk("ww_mem_a_hold", mem_a, 32'h203);
    set_ch(1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    cyc(1);

    // ch1 signed word read-back
    set_ch(1, 1'b1, 1'b0, 3'b110, 32'h200, 32'h0);
    cyc(5);
    chk("rw_done_t5", 32'(ch_done), 32'd0);
    cyc(1);
    chk("rw_done_t6", 32'(ch_done), 32'b10);
    chk("rw_rdata", rdata, 32'hDEADBEEF);
    set_ch(1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    cyc(1);

    // both channels continuously valid
    set_ch(0, 1'b1, 1'b0, 3'b000, 32'h100, 32'h0);
    set_ch(1, 1'b1, 1'b0, 3'b001, 32'h110, 32'h0);
    for (int c = 1; c <= 17; c++) begin
      cyc(1);
      exp_done = (c == 3 || c == 12) ? 2'b01 : (c == 8 || c == 17) ? 2'b10 : 2'b00;
      chk("rr_done", 32'(ch_done), 32'(exp_done));
      if (c == 3 || c == 12) chk("rr_rdata0", rdata, 32'h00000080);
      if (c == 8 || c == 17) chk("rr_rdata1", rdata, 32'h00009234);
    end
    ch_valid = '0;
    cyc(1);

    // flush during a word read
    set_ch(0, 1'b1, 1'b0, 3'b010, 32'h200, 32'h0);
    cyc(2);
    flush_in = 1'b1;
    ch_valid = '0;
    cyc(1);
    flush_in = 1'b0;
    chk("fr_state", 32'(dut.state), 32'(ST_IDLE));
    chk("fr_wr", 32'(mem_wr), 32'd0);
    for (int c = 0; c < 4; c++) begin
      chk("fr_no_done", 32'(ch_done), 32'd0);
      cyc(1);
    end

    // flush during a word write
    set_ch(0, 1'b1, 1'b1, 3'b010, 32'h204, 32'h11223344);
    cyc(1);
    chk("fw_mem_a_t1", mem_a, 32'h204);
    cyc(1);
    flush_in = 1'b1;
    cyc(1);
    flush_in = 1'b0;
    chk("fw_mem_a_t3", mem_a, 32'h206);
    chk("fw_dout_t3", 32'(mem_dout), 32'h22);
    chk("fw_wr_t3", 32'(mem_wr), 32'd1);
    cyc(2);
    chk("fw_done_t5", 32'(ch_done), 32'b01);
    chk("fw_rdata", rdata, 32'd0);
    set_ch(0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    cyc(1);

    // IO write held off while the sink is full
    io_buffer_full = 1'b1;
    set_ch(0, 1'b1, 1'b0, 3'b000, 32'h100, 32'h0);
    set_ch(1, 1'b1, 1'b1, 3'b000, 32'h00030000, 32'h5A);
    cyc(1);
    chk("io_first_a", mem_a, 32'h100);
    chk("io_first_wr", 32'(mem_wr), 32'd0);
    cyc(2);
    chk("io_ch0_done", 32'(ch_done), 32'b01);
    io_buffer_full = 1'b0;
    ch_valid[0] = 1'b0;
    cyc(1);
    chk("io_idle_wr", 32'(mem_wr), 32'd0);
    cyc(1);
    chk("io_mem_a", mem_a, 32'h00030000);
    chk("io_wr", 32'(mem_wr), 32'd1);
    chk("io_dout", 32'(mem_dout), 32'h5A);
    cyc(1);
    chk("io_done", 32'(ch_done), 32'b10);
    chk("io_mem_a_zero", mem_a, 32'd0);
    ch_valid = '0;
    cyc(1);

    // rdy_in low for two cycles during a signed half-word read
    set_ch(0, 1'b1, 1'b0, 3'b101, 32'h110, 32'h0);
    cyc(1);
    chk("rdy_mem_a_t1", mem_a, 32'h110);
    rdy_in = 1'b0;
    cyc(2);
    rdy_in = 1'b1;
    chk("rdy_mem_a_frozen", mem_a, 32'h110);
    cyc(1);
    chk("rdy_mem_a_b1", mem_a, 32'h111);
    cyc(1);
    chk("rdy_done_early", 32'(ch_done), 32'd0);
    cyc(1);
    chk("rdy_done", 32'(ch_done), 32'b01);
    chk("rdy_rdata", rdata, 32'hFFFF9234);
    ch_valid = '0;
    cyc(1);

    // reset mid-write, with rdy_in low
    set_ch(1, 1'b1, 1'b1, 3'b010, 32'h208, 32'hCAFEF00D);
    cyc(2);
    chk("mr_wr_before", 32'(mem_wr), 32'd1);
    rst_n_in = 1'b0;
    rdy_in = 1'b0;
    cyc(1);
    chk("mr_state", 32'(dut.state), 32'(ST_IDLE));
    chk("mr_done", 32'(ch_done), 32'd0);
    chk("mr_wr", 32'(mem_wr), 32'd0);
    chk("mr_mem_a", mem_a, 32'd0);
    chk("mr_dout", 32'(mem_dout), 32'd0);
    chk("mr_rdata", rdata, 32'd0);
    rst_n_in = 1'b1;
    rdy_in = 1'b1;
    ch_valid = '0;
    cyc(4);
    chk("mr_no_done", 32'(ch_done), 32'd0);

    // address wrap across 2^32
    set_ch(0, 1'b1, 1'b1, 3'b010, 32'hFFFFFFFE, 32'h0);
    cyc(3);
    chk("wrap_a_t3", mem_a, 32'h00000000);
    cyc(1);
    chk("wrap_a_t4", mem_a, 32'h00000001);
    cyc(1);
    chk("wrap_done", 32'(ch_done), 32'b01);
    ch_valid = '0;
    cyc(1);

    // illegal len behaves as a single byte with zero result
    set_ch(0, 1'b1, 1'b0, 3'b011, 32'h100, 32'h0);
    cyc(2);
    chk("il_a_t2", mem_a, 32'h100);
    chk("il_state_t2", 32'(dut.state), 32'(ST_LAST));
    cyc(1);
    chk("il_done", 32'(ch_done), 32'b01);
    chk("il_rdata", rdata, 32'd0);
    ch_valid = '0;
    cyc(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
